// File: rtl/key_loader.sv
// key_loader: serial key loader for a logic-locked netlist.
// Key bits arrive LSB first, followed by one even-parity bit. The key is
// released on key_out only after its parity has been verified. Failed loads
// count against a saturating retry budget. Once the budget is spent the
// block stays in ERROR until reset.
module key_loader #(
    parameter int KEY_W     = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_locked,
    output logic             key_err
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int RET_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] LOCKED = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    logic [2:0]       state, state_nxt;
    // Key bits occupy [KEY_W-1:0]. The parity bit lands in [KEY_W].
    logic [KEY_W:0]   sr;
    logic [CNT_W-1:0] cnt;
    logic [RET_W-1:0] retry;

    logic accept, last_bit, par_ok, can_retry, start_load;

    assign accept     = key_valid && (state == SHIFT);
    assign last_bit   = accept && (cnt == CNT_W'(KEY_W));
    assign par_ok     = ~^sr;
    assign can_retry  = retry < RET_W'(MAX_RETRY);
    assign start_load = (state != SHIFT) && (state_nxt == SHIFT);

    // Next-state logic. key_start is only honoured in IDLE and ERROR.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = CHECK;
            CHECK:   state_nxt = par_ok ? LOCKED : ERROR;
            LOCKED:  state_nxt = LOCKED;
            ERROR:   if (key_start && can_retry) state_nxt = SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Shift register and bit counter. Both are cleared at the start of each
    // load. The counter stops at KEY_W so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start_load) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr[cnt] <= key_bit;
            if (cnt != CNT_W'(KEY_W)) cnt <= cnt + CNT_W'(1);
        end
    end

    // Saturating retry counter. It advances on each failed parity check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  retry <= '0;
        else if (state == CHECK && !par_ok && can_retry) retry <= retry + RET_W'(1);
    end

    // key_out is loaded on the CHECK->LOCKED edge and held only while LOCKED.
    // It is zero otherwise, so the netlist never sees a partial key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          key_out <= '0;
        else if (state == CHECK && par_ok) key_out <= sr[KEY_W-1:0];
        else if (state != LOCKED)         key_out <= '0;
    end

    assign key_ready  = (state == SHIFT);
    assign key_locked = (state == LOCKED);
    assign key_err    = (state == ERROR);

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: directed, table-driven bench for key_loader (KEY_W=2, MAX_RETRY=3).
// Each record gives one cycle of inputs and the outputs expected after that edge.
// Hand-written sequences cover asynchronous reset between clock edges.
module tb_key_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [1:0] key_out;
    logic       key_locked;
    logic       key_err;

    key_loader #(.KEY_W(2), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_out   (key_out),
        .key_locked(key_locked),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, valid, bit_v;
        logic       rdy;
        logic [1:0] out;
        logic       lk, er;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, s, v, b, input logic rd, input logic [1:0] o,
                       input logic l, e, input string nm);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.bit_v = b;
        t.rdy = rd; t.out = o; t.lk = l; t.er = e; t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic rd, input logic [1:0] o,
                         input logic l, input logic e);
        n_vec++;
        if ({key_ready, key_out, key_locked, key_err} !== {rd, o, l, e}) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b out=%b lk=%b err=%b, want rdy=%b out=%b lk=%b err=%b",
                     nm, key_ready, key_out, key_locked, key_err, rd, o, l, e);
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare just after the edge.
    task automatic step(input vec_t t);
        rst = t.rst; key_start = t.start; key_valid = t.valid; key_bit = t.bit_v;
        @(posedge clk);
        #1;
        check(t.name, t.rdy, t.out, t.lk, t.er);
    endtask

    initial begin
        //   rst st vl bt  rdy out   lk er
        add(1, 0, 0, 0,   0, 2'd0, 0, 0, "reset");
        add(0, 0, 0, 0,   0, 2'd0, 0, 0, "idle");
        // Good load: bits 1,0 then parity 1 gives key 01.
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "g_start");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "g_b0");
        add(0, 0, 1, 0,   1, 2'd0, 0, 0, "g_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "g_par");
        add(0, 0, 0, 0,   0, 2'd1, 1, 0, "g_lock");
        // LOCKED ignores new starts and bit streams.
        add(0, 1, 1, 1,   0, 2'd1, 1, 0, "lk_start");
        add(0, 0, 1, 0,   0, 2'd1, 1, 0, "lk_b0");
        add(0, 0, 1, 1,   0, 2'd1, 1, 0, "lk_b1");
        add(0, 0, 1, 1,   0, 2'd1, 1, 0, "lk_b2");
        add(1, 0, 0, 0,   0, 2'd0, 0, 0, "rst2");
        // A start with a valid bit in IDLE drops the bit. Gaps in key_valid and a start mid-load are ignored.
        add(0, 1, 1, 1,   1, 2'd0, 0, 0, "gp_start_bit");
        add(0, 0, 0, 0,   1, 2'd0, 0, 0, "gp_gap0");
        add(0, 0, 1, 0,   1, 2'd0, 0, 0, "gp_b0");
        add(0, 0, 0, 1,   1, 2'd0, 0, 0, "gp_gap1");
        add(0, 1, 0, 1,   1, 2'd0, 0, 0, "gp_restart");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "gp_b1");
        add(0, 0, 0, 0,   1, 2'd0, 0, 0, "gp_gap2");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "gp_par");
        add(0, 1, 0, 0,   0, 2'd2, 1, 0, "gp_lock");
        // Three bad loads exhaust the retry budget.
        add(1, 0, 0, 0,   0, 2'd0, 0, 0, "rst3");
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "b1_start");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "b1_b0");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "b1_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "b1_par");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "b1_err");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "b1_hold");
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "b2_start");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "b2_b0");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "b2_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "b2_par");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "b2_err");
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "b3_start");
        add(0, 0, 1, 0,   1, 2'd0, 0, 0, "b3_b0");
        add(0, 0, 1, 0,   1, 2'd0, 0, 0, "b3_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "b3_par");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "b3_err");
        add(0, 1, 0, 0,   0, 2'd0, 0, 1, "ex_start");
        add(0, 0, 1, 1,   0, 2'd0, 0, 1, "ex_b0");
        add(0, 0, 1, 0,   0, 2'd0, 0, 1, "ex_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 1, "ex_par");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "ex_hold");
        // Reset clears the retry budget. Two failures followed by a good retry lock the key.
        add(1, 0, 0, 0,   0, 2'd0, 0, 0, "rst4");
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "r1_start");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "r1_b0");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "r1_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "r1_par");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "r1_err");
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "r2_start");
        add(0, 0, 1, 0,   1, 2'd0, 0, 0, "r2_b0");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "r2_b1");
        add(0, 0, 1, 0,   0, 2'd0, 0, 0, "r2_par");
        add(0, 0, 0, 0,   0, 2'd0, 0, 1, "r2_err");
        add(0, 1, 0, 0,   1, 2'd0, 0, 0, "r3_start");
        add(0, 0, 1, 1,   1, 2'd0, 0, 0, "r3_b0");
        add(0, 0, 1, 0,   1, 2'd0, 0, 0, "r3_b1");
        add(0, 0, 1, 1,   0, 2'd0, 0, 0, "r3_par");
        add(0, 0, 0, 0,   0, 2'd1, 1, 0, "r3_lock");

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset while LOCKED clears the outputs without a clock edge.
        rst = 1'b1; key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        #2;
        check("async_rst_lock", 1'b0, 2'd0, 1'b0, 1'b0);
        begin
            vec_t t;
            t.rst = 0; t.start = 1; t.valid = 0; t.bit_v = 0;
            t.rdy = 1; t.out = 2'd0; t.lk = 0; t.er = 0; t.name = "ar_start";
            step(t);
            t.start = 0; t.valid = 1; t.bit_v = 1; t.name = "ar_b0";
            step(t);
        end
        // Reset after one accepted bit, mid-cycle. The partial load must be discarded.
        rst = 1'b1; key_valid = 1'b0;
        #2;
        check("async_rst_shift", 1'b0, 2'd0, 1'b0, 1'b0);
        begin
            vec_t t;
            t.rst = 0; t.valid = 0; t.bit_v = 0;
            t.start = 1; t.rdy = 1; t.out = 2'd0; t.lk = 0; t.er = 0; t.name = "rl_start";
            step(t);
            t.start = 0; t.valid = 1; t.bit_v = 1; t.name = "rl_b0";
            step(t);
            t.name = "rl_b1";
            step(t);
            t.bit_v = 0; t.rdy = 0; t.name = "rl_par";
            step(t);
            t.valid = 0; t.out = 2'd3; t.lk = 1; t.name = "rl_lock";
            step(t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
